// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART serial receiver: 8N1 frame recovery with bus-readable status flags
module spart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  input  logic [1:0] ioaddr,
  input  logic       iorw,
  output logic       rda,
  output logic [7:0] rx_data,
  output logic       framing_err,
  output logic       overrun
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  logic                   rxs_prev_q, rxs_prev_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   rda_q, rda_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;
  logic                   rxs, rd, armed, complete;

  assign rxs   = sync_q[SYNC_STAGES-1];
  assign rd    = (ioaddr == 2'b00) && iorw;
  // Reset-time 1s in the chain are not real line samples; ignore edges until they have flushed.
  assign armed = vld_q[SYNC_STAGES];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
    vld_d      = {vld_q[SYNC_STAGES-1:0], 1'b1};
    rxs_prev_d = rxs;
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    rda_d      = rda_q;
    fe_d       = fe_q;
    ovr_d      = ovr_q;
    complete   = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed && rxs_prev_q && !rxs) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (enable) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (enable) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (enable) begin
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A read landing on the completion cycle consumes the old byte, so no overrun.
    if (complete) begin
      data_d = shift_q;
      fe_d   = ~rxs;
      ovr_d  = rda_q && !rd;
      rda_d  = 1'b1;
    end else if (rd) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync_q     <= '1;
      vld_q      <= '0;
      rxs_prev_q <= 1'b1;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      rda_q      <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      vld_q      <= vld_d;
      rxs_prev_q <= rxs_prev_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      rda_q      <= rda_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rda         = rda_q;
  assign rx_data     = data_q;
  assign framing_err = fe_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - scoreboard bench for spart_rx with randomized 8N1 frames
module tb_spart_rx;

  logic       clk, rst, enable, rxd, iorw;
  logic [1:0] ioaddr;
  logic       rda, framing_err, overrun;
  logic [7:0] rx_data;

  spart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rxd(rxd),
    .ioaddr(ioaddr), .iorw(iorw), .rda(rda), .rx_data(rx_data),
    .framing_err(framing_err), .overrun(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;

  // Expected completion record: {data, framing_err, overrun}
  logic [9:0] exp_q[$];
  logic       unread    = 1'b0;
  logic [7:0] last_data = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick every 4th clock
  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      ecnt++;
      enable = (ecnt % 4 == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  // Monitor: a completion shows as rda rising or, with rda held, any change of data/flags.
  logic       p_rda = 1'b0, p_fe = 1'b0, p_ov = 1'b0;
  logic [7:0] p_data = 8'h00;
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && rda === 1'b1 &&
          (!p_rda || rx_data != p_data || overrun != p_ov || framing_err != p_fe)) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte got=%h required=none", rx_data);
        end else begin
          e = exp_q.pop_front();
          if ({rx_data, framing_err, overrun} !== e) begin
            n_fail++;
            $display("FAIL byte got=%h fe=%b ov=%b required=%h fe=%b ov=%b",
                     rx_data, framing_err, overrun, e[9:2], e[1], e[0]);
          end
        end
      end
      p_rda = rda; p_data = rx_data; p_fe = framing_err; p_ov = overrun;
    end
  end

  // Reference: overrun iff an unread byte exists and no read coincides with completion.
  task automatic model_push(input logic [7:0] b, input logic stop, input logic race);
    exp_q.push_back({b, ~stop, unread & ~race});
    unread    = 1'b1;
    last_data = b;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic race);
    model_push(b, stop, race);
    @(negedge clk);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (64) @(negedge clk);
    end
    rxd = stop;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic access(input logic [1:0] a, input logic rw);
    @(negedge clk);
    ioaddr = a;
    iorw   = rw;
    @(negedge clk);
    iorw   = 1'b0;
    ioaddr = 2'b00;
  endtask

  task automatic do_read();
    access(2'b00, 1'b1);
    unread = 1'b0;
    chk("rd_clears_rda", rda, 0);
    chk("rd_clears_ovr", overrun, 0);
    chk("rd_keeps_data", rx_data, last_data);
  endtask

  // Pulse rd on exactly the stop-sampling enable: 2 sync stages + 1 IDLE->START cycle,
  // then 8 + 8*16 + 16 enables into the frame.
  task automatic race_rd();
    int cnt = 0;
    logic hit = 1'b0;
    @(negedge clk);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 4000 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (enable) begin
        cnt++;
        if (cnt == 152) hit = 1'b1;
      end
    end
    chk("race_enable_found", hit, 1);
    ioaddr = 2'b00;
    iorw   = 1'b1;
    @(negedge clk);
    iorw   = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    rst = 1'b0; rxd = 1'b0; ioaddr = 2'b00; iorw = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rda", rda, 0);
    chk("reset_fe", framing_err, 0);
    chk("reset_ovr", overrun, 0);
    chk("reset_data", rx_data, 0);
    rst = 1'b1;
    repeat (800) @(negedge clk);
    chk("break_no_start", rda, 0);
    rxd = 1'b1;
    repeat (40) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_rda", rda, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_fe", framing_err, 0);
    access(2'b01, 1'b1);
    access(2'b00, 1'b0);
    chk("other_access_keeps_rda", rda, 1);
    do_read();

    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_rda", rda, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("3c_data", rx_data, 8'h3C);
    do_read();

    send_frame(8'h5A, 1'b0, 1'b0);
    chk("5a_fe", framing_err, 1);
    chk("5a_data", rx_data, 8'h5A);
    do_read();
    chk("fe_survives_read", framing_err, 1);
    repeat (30) @(negedge clk);
    send_frame(8'h01, 1'b1, 1'b0);
    chk("01_fe_clear", framing_err, 0);
    do_read();

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_set", overrun, 1);
    chk("ovr_data", rx_data, 8'h22);
    do_read();

    send_frame(8'h66, 1'b1, 1'b0);
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      race_rd();
    join
    chk("race_rda", rda, 1);
    chk("race_ovr", overrun, 0);
    chk("race_data", rx_data, 8'h77);
    do_read();

    send_frame(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    rxd = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    unread = 1'b0;
    last_data = 8'h00;
    repeat (800) @(negedge clk);
    chk("midreset_rda", rda, 0);
    chk("midreset_fe", framing_err, 0);
    chk("midreset_data", rx_data, 0);

    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s, 1'b0);
      chk("rand_fe", framing_err, {31'd0, ~s});
      do_read();
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    repeat (100) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
